loop_stack_ctrl: RTL
====================

// Module: loop_stack_ctrl
// PURPOSE
//  Sequences the loop-return stack RAM (1-cycle registered read, 32-bit addr) for the bracket
//  instructions. Core hands each '['/']' (and, while skipping, every instruction) over a
//  cmd handshake; block pushes/peeks/pops the RAM, runs forward-skip nesting count, returns next PC.
// PARAMETERS
//  I_ADDR_WIDTH    16     instruction address width; equals stack RAM data width
//  MAX_LOOP_DEPTH  256    stack RAM entries; max open-loop nesting
// PORTS
//  clk         in   1      clock, all state on posedge
//  rst_n       in   1      asynchronous active-low reset
//  cmd_valid   in   1      command offered
//  cmd_ready   out  1      command accepted when valid&ready
//  cmd_op      in   2      00 OTHER, 01 OPEN '[', 10 CLOSE ']', 11 treated as OTHER
//  cmd_pc      in   IAW    PC of the instruction
//  cell_zero   in   1      current data cell == 0, sampled with the command
//  rsp_valid   out  1      one-cycle pulse, response fields valid; no backpressure
//  rsp_jump    out  1      1: target is a backward jump
//  rsp_target  out  IAW    next PC
//  skipping    out  1      level: state==SKIP; core discards instruction effects
//  err         out  1      sticky error (overflow/underflow)
//  depth       out  32     current stack occupancy
//  stk_we      out  1      RAM write enable (combinational)
//  stk_waddr   out  32     = depth
//  stk_wdata   out  IAW    = cmd_pc
//  stk_raddr   out  32     = depth-1 when depth>0, else 0 (combinational)
//  stk_rdata   in   IAW    RAM read data, valid cycle after stk_raddr presented
// BEHAVIOUR
//  Reset: state IDLE, depth=0, nest=0, err=0, rsp_valid=0, rsp_jump=0, rsp_target=0.
//  States IDLE, SKIP, RD, HALT. cmd_ready=1 in IDLE/SKIP, 0 in RD/HALT.
//  All rsp_* registered: accept in cycle N -> rsp_valid in N+1, except CLOSE-nonzero -> N+2.
//  IDLE, accepted:
//   OTHER: rsp target=cmd_pc+1, jump=0.
//   OPEN, !cell_zero, depth<MAX: stk_we=1 in cycle N; depth+1; rsp target=cmd_pc+1.
//   OPEN, cell_zero: -> SKIP, nest=0; rsp target=cmd_pc+1, jump=0; no RAM access.
//   CLOSE, !cell_zero, depth>0: -> RD; next cycle rsp target=stk_rdata+1, jump=1,
//    depth unchanged (peek); -> IDLE.
//   CLOSE, cell_zero, depth>0: depth-1 (pop); rsp target=cmd_pc+1, jump=0.
//   OPEN push with depth==MAX, or CLOSE with depth==0: no RAM write, depth unchanged;
//    err=1, rsp target=cmd_pc, jump=0; -> HALT.
//  SKIP, accepted (every instruction): OPEN nest+1; CLOSE with nest>0 nest-1;
//   CLOSE with nest==0 -> IDLE; rsp target=cmd_pc+1, jump=0 for all; no RAM access.
//   cell_zero ignored in SKIP.
//  HALT: hold until rst_n low; no RAM writes.
//  PC arithmetic modulo 2^IAW (0xFFFF+1 -> 0x0000). nest is 32-bit, no overflow check.
//  Push in N then CLOSE accepted N+1: RAM write lands end of N, read addr=new top, sees new data.
//  Reset asserted mid-RD/SKIP: immediate return to reset state; pending response dropped.
// TESTING
//  OPEN pc=0x10 cell!=0 -> we=1 waddr=0 wdata=0x10, depth=1, rsp target=0x11 jump=0 next cycle.
//  then CLOSE pc=0x20 cell!=0 -> raddr=0, rsp 2 cycles later target=0x11 jump=1, depth=1;
//   CLOSE pc=0x20 cell=0 -> depth=0, target=0x21.
//  OPEN pc=5 cell=0, then OPEN,OTHER,CLOSE,CLOSE pc=6..9 -> skipping=1 until CLOSE pc=9
//   accepted, all targets pc+1, depth stays 0, no stk_we.
//  256 nonzero OPENs then a 257th -> depth=256, err=1, no write, cmd_ready=0 after.
//  CLOSE at depth 0 -> err=1, HALT; rst_n low -> err=0, depth=0, cmd_ready=1.
//  OPEN pc=0xFFFF cell!=0 -> target=0x0000; back-to-back push then CLOSE -> target=pushed pc+1.

Source files
------------

// File: rtl/loop_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : loop_stack_ctrl
// Purpose  : Sequences the loop-return stack RAM for '[' / ']' bracket
//            instructions, including forward-skip nesting while a loop body
//            is bypassed.
// Revision : 1.0
// ============================================================================
module loop_stack_ctrl #(
  parameter int I_ADDR_WIDTH   = 16,
  parameter int MAX_LOOP_DEPTH = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [I_ADDR_WIDTH-1:0] cmd_pc,
  input  logic                    cell_zero,
  output logic                    rsp_valid,
  output logic                    rsp_jump,
  output logic [I_ADDR_WIDTH-1:0] rsp_target,
  output logic                    skipping,
  output logic                    err,
  output logic [31:0]             depth,
  output logic                    stk_we,
  output logic [31:0]             stk_waddr,
  output logic [I_ADDR_WIDTH-1:0] stk_wdata,
  output logic [31:0]             stk_raddr,
  input  logic [I_ADDR_WIDTH-1:0] stk_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_RD   = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  localparam logic [1:0]  OP_OPEN   = 2'b01;
  localparam logic [1:0]  OP_CLOSE  = 2'b10;
  localparam logic [31:0] MAX_DEPTH = 32'(MAX_LOOP_DEPTH);

  state_t                  state_q, state_d;
  logic [31:0]             depth_q, depth_d;
  logic [31:0]             nest_q, nest_d;
  logic                    err_q, err_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    rsp_jump_q, rsp_jump_d;
  logic [I_ADDR_WIDTH-1:0] rsp_target_q, rsp_target_d;

  logic                    accept;
  logic [I_ADDR_WIDTH-1:0] pc_inc;

  assign cmd_ready = (state_q == ST_IDLE) || (state_q == ST_SKIP);
  assign accept    = cmd_valid && cmd_ready;
  assign pc_inc    = cmd_pc + I_ADDR_WIDTH'(1);

  assign skipping   = (state_q == ST_SKIP);
  assign err        = err_q;
  assign depth      = depth_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_jump   = rsp_jump_q;
  assign rsp_target = rsp_target_q;

  // Read address always tracks the current top so a peek needs no extra cycle.
  assign stk_waddr = depth_q;
  assign stk_wdata = cmd_pc;
  assign stk_raddr = (depth_q != 32'd0) ? (depth_q - 32'd1) : 32'd0;

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    nest_d       = nest_q;
    err_d        = err_q;
    rsp_valid_d  = 1'b0;
    rsp_jump_d   = rsp_jump_q;
    rsp_target_d = rsp_target_q;
    stk_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rsp_valid_d  = 1'b1;
          rsp_jump_d   = 1'b0;
          rsp_target_d = pc_inc;
          if (cmd_op == OP_OPEN) begin
            if (cell_zero) begin
              state_d = ST_SKIP;
              nest_d  = 32'd0;
            end else if (depth_q < MAX_DEPTH) begin
              stk_we  = 1'b1;
              depth_d = depth_q + 32'd1;
            end else begin
              err_d        = 1'b1;
              rsp_target_d = cmd_pc;
              state_d      = ST_HALT;
            end
          end else if (cmd_op == OP_CLOSE) begin
            if (depth_q == 32'd0) begin
              err_d        = 1'b1;
              rsp_target_d = cmd_pc;
              state_d      = ST_HALT;
            end else if (cell_zero) begin
              depth_d = depth_q - 32'd1;
            end else begin
              // Backward jump: response waits one cycle for the RAM read.
              rsp_valid_d  = 1'b0;
              rsp_jump_d   = rsp_jump_q;
              rsp_target_d = rsp_target_q;
              state_d      = ST_RD;
            end
          end
        end
      end

      ST_SKIP: begin
        if (accept) begin
          rsp_valid_d  = 1'b1;
          rsp_jump_d   = 1'b0;
          rsp_target_d = pc_inc;
          if (cmd_op == OP_OPEN) begin
            nest_d = nest_q + 32'd1;
          end else if (cmd_op == OP_CLOSE) begin
            if (nest_q != 32'd0) begin
              nest_d = nest_q - 32'd1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_RD: begin
        rsp_valid_d  = 1'b1;
        rsp_jump_d   = 1'b1;
        rsp_target_d = stk_rdata + I_ADDR_WIDTH'(1);
        state_d      = ST_IDLE;
      end

      ST_HALT: begin
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      depth_q      <= 32'd0;
      nest_q       <= 32'd0;
      err_q        <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_jump_q   <= 1'b0;
      rsp_target_q <= '0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      nest_q       <= nest_d;
      err_q        <= err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_jump_q   <= rsp_jump_d;
      rsp_target_q <= rsp_target_d;
    end
  end

endmodule
`default_nettype wire
